reg_seq_master: RTL



---
 rtl/reg_seq_master.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/reg_seq_master.sv
// reg_seq_master: command-driven initiator for the 16x8 register-file slave (single writes,
// fill bursts, wrapping read bursts). Define REG_SEQ_MASTER_VERIFY_EN to add write readback checking.
module reg_seq_master #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [ADDR_W-1:0] cmd_len,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              done,
  output logic              verify_err,
  output logic              reg_wr_en,
  output logic              reg_rd_en,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_wdata,
  input  logic [DATA_W-1:0] reg_rdata
);

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
`ifdef REG_SEQ_MASTER_VERIFY_EN
    VRD,
    VDRAIN,
`endif
    DRAIN
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] len_q;
  logic [ADDR_W-1:0] cnt;
  logic              pipe_rd;
  logic [ADDR_W-1:0] pipe_addr;

`ifdef REG_SEQ_MASTER_VERIFY_EN
  logic [ADDR_W-1:0] base_q;
  logic              chk_valid;
  logic [DATA_W-1:0] chk_data;
`else
  assign verify_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state     <= IDLE;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_addr  <= '0;
      rsp_rdata <= '0;
      done      <= 1'b0;
      reg_wr_en <= 1'b0;
      reg_rd_en <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      len_q     <= '0;
      cnt       <= '0;
      pipe_rd   <= 1'b0;
      pipe_addr <= '0;
`ifdef REG_SEQ_MASTER_VERIFY_EN
      base_q     <= '0;
      chk_valid  <= 1'b0;
      chk_data   <= '0;
      verify_err <= 1'b0;
`endif
    end else begin
      rsp_valid <= 1'b0;
      done      <= 1'b0;

      // The slave answers one edge after it samples rd_en; track which beat is in flight.
      pipe_rd   <= reg_rd_en;
      pipe_addr <= reg_addr;
      if (pipe_rd && (state == READ || state == DRAIN)) begin
        rsp_valid <= 1'b1;
        rsp_addr  <= pipe_addr;
        rsp_rdata <= reg_rdata;
      end

`ifdef REG_SEQ_MASTER_VERIFY_EN
      // Readback data is compared one edge after capture, so the flag settles with done.
      chk_valid <= pipe_rd && (state == VRD || state == VDRAIN);
      chk_data  <= reg_rdata;
      if (chk_valid && (chk_data != reg_wdata)) begin
        verify_err <= 1'b1;
      end
`endif

      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            len_q     <= cmd_len;
            cnt       <= '0;
            reg_addr  <= cmd_addr;
            reg_wdata <= cmd_wdata;
`ifdef REG_SEQ_MASTER_VERIFY_EN
            base_q     <= cmd_addr;
            verify_err <= 1'b0;
`endif
            if (cmd_write) begin
              reg_wr_en <= 1'b1;
              state     <= WRITE;
            end else begin
              reg_rd_en <= 1'b1;
              state     <= READ;
            end
          end
        end

        WRITE: begin
          if (cnt == len_q) begin
            reg_wr_en <= 1'b0;
`ifdef REG_SEQ_MASTER_VERIFY_EN
            reg_rd_en <= 1'b1;
            reg_addr  <= base_q;
            cnt       <= '0;
            state     <= VRD;
`else
            done      <= 1'b1;
            cmd_ready <= 1'b1;
            state     <= IDLE;
`endif
          end else begin
            cnt      <= cnt + ADDR_W'(1);
            reg_addr <= reg_addr + ADDR_W'(1);
          end
        end

        READ: begin
          if (cnt == len_q) begin
            reg_rd_en <= 1'b0;
            state     <= DRAIN;
          end else begin
            cnt      <= cnt + ADDR_W'(1);
            reg_addr <= reg_addr + ADDR_W'(1);
          end
        end

        DRAIN: begin
          done      <= 1'b1;
          cmd_ready <= 1'b1;
          state     <= IDLE;
        end

`ifdef REG_SEQ_MASTER_VERIFY_EN
        VRD: begin
          if (cnt == len_q) begin
            reg_rd_en <= 1'b0;
            state     <= VDRAIN;
          end else begin
            cnt      <= cnt + ADDR_W'(1);
            reg_addr <= reg_addr + ADDR_W'(1);
          end
        end

        VDRAIN: begin
          if (!pipe_rd && chk_valid) begin
            done      <= 1'b1;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end
`endif

        default: begin
          reg_wr_en <= 1'b0;
          reg_rd_en <= 1'b0;
          cmd_ready <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
